// File: rtl/alu_dispatcher_pkg.sv
// Shared constants for the matrix ALU dispatcher: opcodes, bus geometry, FSM encoding.
package alu_dispatcher_pkg;

   localparam int MAT_W           = 256;
   localparam int ELEM_W          = 16;
   localparam int TIMEOUT_DEFAULT = 16;

   typedef logic [MAT_W-1:0] matrix_t;
   typedef logic [2:0]       opcode_t;

   localparam opcode_t OP_ADD       = 3'd0;
   localparam opcode_t OP_SUBTRACT  = 3'd1;
   localparam opcode_t OP_TRANSPOSE = 3'd2;
   localparam opcode_t OP_SCALE     = 3'd3;
   localparam opcode_t OP_MULTIPLY  = 3'd4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD_A = 3'd1;
   localparam logic [2:0] ST_LOAD_B = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_RESP   = 3'd4;

   function automatic logic needsOperandB(input opcode_t op);
      return op != OP_TRANSPOSE;
   endfunction

   function automatic logic isLegalOp(input opcode_t op);
      return op <= OP_MULTIPLY;
   endfunction

endpackage

// File: rtl/alu_dispatcher_if.sv
// Command/response handshake plus ALU-side control and data bus of the dispatcher.
interface alu_dispatcher_if;
   import alu_dispatcher_pkg::*;

   logic    cmdValid;
   logic    cmdReady;
   opcode_t cmdOpCode;
   matrix_t cmdOperandA;
   matrix_t cmdOperandB;

   logic    rspValid;
   logic    rspReady;
   matrix_t rspMatrix;
   logic    rspError;

   opcode_t opCode;
   logic    readnWrite;
   logic    nALUenable;
   logic    matrixIndicator;
   matrix_t dataBusOut;
   logic    dataBusOE;
   matrix_t dataBusIn;
   logic    aluDone;

   modport master (
      input  cmdValid, cmdOpCode, cmdOperandA, cmdOperandB, rspReady, dataBusIn, aluDone,
      output cmdReady, rspValid, rspMatrix, rspError,
             opCode, readnWrite, nALUenable, matrixIndicator, dataBusOut, dataBusOE
   );

   modport slave (
      output cmdValid, cmdOpCode, cmdOperandA, cmdOperandB, rspReady, dataBusIn, aluDone,
      input  cmdReady, rspValid, rspMatrix, rspError,
             opCode, readnWrite, nALUenable, matrixIndicator, dataBusOut, dataBusOE
   );

endinterface

// File: rtl/alu_dispatcher_exec_watchdog.sv
// EXEC-phase cycle counter; saturates at the timeout value and flags it while enabled.
module alu_dispatcher_exec_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr_i,
   input  logic       en_i,
   output logic [4:0] count_o,
   output logic       timeout_o
);

   localparam logic [4:0] LAST = 5'(TIMEOUT_CYCLES - 1);

   logic [4:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != LAST)) begin
         count_d = count_q + 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign timeout_o = en_i && (count_q == LAST);

endmodule

// File: rtl/alu_dispatcher.sv
// Sequences one matrix-ALU command: load A, optional load B/scalar, execute, capture result.
// All ALU-side outputs are registered so the shared bus is released cleanly on the next edge.
module alu_dispatcher
   import alu_dispatcher_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input logic              clk,
   input logic              reset,
   alu_dispatcher_if.master dp
);

   logic [2:0] state_q, state_d;
   opcode_t    op_q, op_d;
   matrix_t    b_q, b_d;
   opcode_t    opcode_q, opcode_d;
   logic       rnw_q, rnw_d;
   logic       nen_q, nen_d;
   logic       ind_q, ind_d;
   logic       oe_q, oe_d;
   matrix_t    bus_q, bus_d;
   matrix_t    rsp_mat_q, rsp_mat_d;
   logic       rsp_err_q, rsp_err_d;

   logic [4:0] wd_count;
   logic       wd_timeout;

   alu_dispatcher_exec_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (state_q != ST_EXEC),
      .en_i      (state_q == ST_EXEC),
      .count_o   (wd_count),
      .timeout_o (wd_timeout)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      b_d       = b_q;
      opcode_d  = opcode_q;
      rnw_d     = rnw_q;
      nen_d     = nen_q;
      ind_d     = ind_q;
      oe_d      = oe_q;
      bus_d     = bus_q;
      rsp_mat_d = rsp_mat_q;
      rsp_err_d = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (dp.cmdValid) begin
               if (!isLegalOp(dp.cmdOpCode)) begin
                  state_d   = ST_RESP;
                  rsp_err_d = 1'b1;
                  rsp_mat_d = '0;
               end else begin
                  state_d  = ST_LOAD_A;
                  op_d     = dp.cmdOpCode;
                  opcode_d = dp.cmdOpCode;
                  // SCALE carries only an 8-bit scalar; the upper bus bits must read zero
                  b_d      = (dp.cmdOpCode == OP_SCALE) ? matrix_t'(dp.cmdOperandB[7:0])
                                                        : dp.cmdOperandB;
                  nen_d    = 1'b0;
                  rnw_d    = 1'b0;
                  ind_d    = 1'b0;
                  oe_d     = 1'b1;
                  bus_d    = dp.cmdOperandA;
               end
            end
         end
         ST_LOAD_A: begin
            if (needsOperandB(op_q)) begin
               state_d = ST_LOAD_B;
               ind_d   = 1'b1;
               bus_d   = b_q;
            end else begin
               state_d = ST_EXEC;
               rnw_d   = 1'b1;
               oe_d    = 1'b0;
               bus_d   = '0;
            end
         end
         ST_LOAD_B: begin
            state_d = ST_EXEC;
            rnw_d   = 1'b1;
            oe_d    = 1'b0;
            ind_d   = 1'b0;
            bus_d   = '0;
         end
         ST_EXEC: begin
            // aluDone in the first EXEC cycle is left over from the previous operation
            if (dp.aluDone && (wd_count != 5'd0)) begin
               state_d   = ST_RESP;
               rsp_mat_d = dp.dataBusIn;
               rsp_err_d = 1'b0;
               nen_d     = 1'b1;
               rnw_d     = 1'b0;
            end else if (wd_timeout) begin
               state_d   = ST_RESP;
               rsp_mat_d = '0;
               rsp_err_d = 1'b1;
               nen_d     = 1'b1;
               rnw_d     = 1'b0;
            end
         end
         ST_RESP: begin
            if (dp.rspReady) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_ADD;
         b_q       <= '0;
         opcode_q  <= '0;
         rnw_q     <= 1'b0;
         nen_q     <= 1'b1;
         ind_q     <= 1'b0;
         oe_q      <= 1'b0;
         bus_q     <= '0;
         rsp_mat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         b_q       <= b_d;
         opcode_q  <= opcode_d;
         rnw_q     <= rnw_d;
         nen_q     <= nen_d;
         ind_q     <= ind_d;
         oe_q      <= oe_d;
         bus_q     <= bus_d;
         rsp_mat_q <= rsp_mat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign dp.cmdReady        = (state_q == ST_IDLE) && !reset;
   assign dp.rspValid        = (state_q == ST_RESP);
   assign dp.rspMatrix       = rsp_mat_q;
   assign dp.rspError        = rsp_err_q;
   assign dp.opCode          = opcode_q;
   assign dp.readnWrite      = rnw_q;
   assign dp.nALUenable      = nen_q;
   assign dp.matrixIndicator = ind_q;
   assign dp.dataBusOut      = bus_q;
   assign dp.dataBusOE       = oe_q;

endmodule

// File: tb/tb_alu_dispatcher.sv
// Bench for alu_dispatcher: behavioural matrix ALU on a modelled shared bus, random and directed commands.
module tb_alu_dispatcher;
   import alu_dispatcher_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_dispatcher_if ifc ();

   alu_dispatcher #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .dp    (ifc)
   );

   int total = 0;
   int bad   = 0;
   int rule_viol = 0;
   int contention = 0;

   function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
      return m[16*(4*r+c) +: 16];
   endfunction

   function automatic logic [255:0] fill(input logic [15:0] v);
      logic [255:0] m;
      for (int i = 0; i < 16; i++) m[16*i +: 16] = v;
      return m;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom;
      return m;
   endfunction

   // Reference matrix arithmetic, element by element, 16-bit wraparound.
   function automatic logic [255:0] ref_op(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b);
      logic [255:0] res;
      logic [15:0]  acc;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            case (op)
               3'd0: acc = el(a, r, c) + el(b, r, c);
               3'd1: acc = el(a, r, c) - el(b, r, c);
               3'd2: acc = el(a, c, r);
               3'd3: acc = el(a, r, c) * {8'd0, b[7:0]};
               default: begin
                  acc = '0;
                  for (int k = 0; k < 4; k++) acc = acc + el(a, r, k) * el(b, k, c);
               end
            endcase
            res[16*(4*r+c) +: 16] = acc;
         end
      end
      return res;
   endfunction

   // Behavioural ALU: latches operands in load phase, raises aluDone in the 4th EXEC cycle.
   logic [255:0] alu_a, alu_b, alu_res;
   logic         alu_drive;
   bit           alu_stuck = 1'b0;
   bit           alu_stale = 1'b0;
   int           alu_cnt;

   always @(posedge clk) begin
      if (reset) begin
         alu_cnt     <= 0;
         ifc.aluDone <= 1'b0;
      end else if (!ifc.nALUenable && ifc.readnWrite) begin
         alu_cnt     <= alu_cnt + 1;
         ifc.aluDone <= !alu_stuck && (alu_cnt + 1 >= 3);
      end else begin
         if (!ifc.nALUenable && ifc.dataBusOE) begin
            if (ifc.matrixIndicator) alu_b <= ifc.dataBusOut;
            else                     alu_a <= ifc.dataBusOut;
         end
         alu_cnt     <= 0;
         ifc.aluDone <= alu_stale && !ifc.nALUenable;
      end
   end

   assign alu_drive     = !ifc.nALUenable && ifc.readnWrite && ifc.aluDone;
   assign alu_res       = ref_op(ifc.opCode, alu_a, alu_b);
   assign ifc.dataBusIn = ifc.dataBusOE ? ifc.dataBusOut : (alu_drive ? alu_res : '0);

   always @(negedge clk) begin
      if (!reset && ifc.dataBusOE && (ifc.readnWrite || ifc.nALUenable)) rule_viol++;
      if (!reset && ifc.dataBusOE && alu_drive) contention++;
   end

   task automatic do_cmd(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b, input int hold,
                         output logic [255:0] mat, output logic err, output int lat,
                         output bit saw_ind1, output bit saw_en, output logic [255:0] lb_bus,
                         output bit stable, output bit idle_rdy, output bit nen_rsp, output bit oe_rsp);
      int n;
      saw_ind1 = 1'b0; saw_en = 1'b0; lb_bus = '0; stable = 1'b1; lat = 0;
      @(negedge clk);
      ifc.cmdValid = 1'b1; ifc.cmdOpCode = op; ifc.cmdOperandA = a; ifc.cmdOperandB = b; ifc.rspReady = 1'b0;
      n = 0;
      while (!ifc.cmdReady && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      ifc.cmdValid = 1'b0;
      ifc.cmdOpCode = 3'($urandom); ifc.cmdOperandA = rand256(); ifc.cmdOperandB = rand256();
      for (int i = 1; i <= 40; i++) begin
         lat = i;
         if (!ifc.nALUenable) saw_en = 1'b1;
         if (ifc.matrixIndicator) saw_ind1 = 1'b1;
         if (!ifc.nALUenable && ifc.dataBusOE && ifc.matrixIndicator) lb_bus = ifc.dataBusOut;
         if (ifc.rspValid) break;
         @(negedge clk);
      end
      nen_rsp = ifc.nALUenable; oe_rsp = ifc.dataBusOE;
      mat = ifc.rspMatrix; err = ifc.rspError;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!ifc.rspValid || ifc.rspMatrix !== mat || ifc.rspError !== err) stable = 1'b0;
      end
      ifc.rspReady = 1'b1;
      @(negedge clk);
      ifc.rspReady = 1'b0;
      idle_rdy = ifc.cmdReady;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (ifc.nALUenable !== 1'b1) begin bad++; $display("FAIL reset_nALUenable got=%b want=1", ifc.nALUenable); end
      total++; if (ifc.readnWrite !== 1'b0) begin bad++; $display("FAIL reset_readnWrite got=%b want=0", ifc.readnWrite); end
      total++; if (ifc.matrixIndicator !== 1'b0) begin bad++; $display("FAIL reset_ind got=%b want=0", ifc.matrixIndicator); end
      total++; if (ifc.dataBusOE !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", ifc.dataBusOE); end
      total++; if (ifc.dataBusOut !== '0) begin bad++; $display("FAIL reset_busout got=%h want=0", ifc.dataBusOut); end
      total++; if (ifc.opCode !== 3'd0) begin bad++; $display("FAIL reset_opcode got=%0d want=0", ifc.opCode); end
      total++; if (ifc.rspValid !== 1'b0 || ifc.rspError !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b want=00", ifc.rspValid, ifc.rspError); end
      total++; if (ifc.rspMatrix !== '0) begin bad++; $display("FAIL reset_rspmat got=%h want=0", ifc.rspMatrix); end
      total++; if (ifc.cmdReady !== 1'b0) begin bad++; $display("FAIL reset_cmdready_high got=%b want=0", ifc.cmdReady); end
      reset = 1'b0;
      @(negedge clk);
      total++; if (ifc.cmdReady !== 1'b1) begin bad++; $display("FAIL reset_cmdready_after got=%b want=1", ifc.cmdReady); end
   endtask

   task automatic test_add();
      logic [255:0] mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      do_cmd(OP_ADD, fill(16'd1), fill(16'd2), 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      total++; if (mat !== fill(16'd3)) begin bad++; $display("FAIL add_result got=%h want=%h", mat, fill(16'd3)); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL add_err got=%b want=0", err); end
      total++; if (lat != 7) begin bad++; $display("FAIL add_latency got=%0d want=7", lat); end
      total++; if (ind1 !== 1'b1 || lb !== fill(16'd2)) begin bad++; $display("FAIL add_load_b ind=%b bus=%h want ind=1 bus=%h", ind1, lb, fill(16'd2)); end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL add_ready_after got=%b want=1", rdy); end
   endtask

   task automatic test_transpose();
      logic [255:0] a, want, mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            a[16*(4*r+c) +: 16]    = 16'(4*r+c);
            want[16*(4*r+c) +: 16] = 16'(4*c+r);
         end
      do_cmd(OP_TRANSPOSE, a, rand256(), 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      total++; if (mat !== want) begin bad++; $display("FAIL transpose_result got=%h want=%h", mat, want); end
      total++; if (ind1 !== 1'b0) begin bad++; $display("FAIL transpose_ind got=%b want=0", ind1); end
      total++; if (lat != 6) begin bad++; $display("FAIL transpose_latency got=%0d want=6", lat); end
   endtask

   task automatic test_scale();
      logic [255:0] b, mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      b = '1;
      b[7:0] = 8'h08;
      do_cmd(OP_SCALE, fill(16'd3), b, 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      total++; if (lb !== 256'd8) begin bad++; $display("FAIL scale_load_b got=%h want=8", lb); end
      total++; if (mat !== fill(16'd24)) begin bad++; $display("FAIL scale_result got=%h want=%h", mat, fill(16'd24)); end
   endtask

   task automatic test_illegal();
      logic [255:0] mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      for (int op = 5; op < 8; op++) begin
         do_cmd(3'(op), rand256(), rand256(), 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
         total++;
         if (lat != 1 || err !== 1'b1 || mat !== '0 || en !== 1'b0) begin
            bad++;
            $display("FAIL illegal_op%0d lat=%0d err=%b en_seen=%b mat=%h want lat=1 err=1 en_seen=0 mat=0", op, lat, err, en, mat);
         end
      end
   endtask

   task automatic test_timeout();
      logic [255:0] mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      alu_stuck = 1'b1;
      do_cmd(OP_ADD, rand256(), rand256(), 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      alu_stuck = 1'b0;
      total++; if (err !== 1'b1 || mat !== '0) begin bad++; $display("FAIL timeout_rsp err=%b mat=%h want err=1 mat=0", err, mat); end
      total++; if (lat != 19) begin bad++; $display("FAIL timeout_latency got=%0d want=19", lat); end
      total++; if (nen !== 1'b1 || oe !== 1'b0) begin bad++; $display("FAIL timeout_release nen=%b oe=%b want nen=1 oe=0", nen, oe); end
   endtask

   task automatic test_stale_done();
      logic [255:0] a, b, mat, lb; logic err; int lat; bit ind1, en, st, rdy, nen, oe;
      a = rand256(); b = rand256();
      alu_stale = 1'b1;
      do_cmd(OP_SUBTRACT, a, b, 0, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      alu_stale = 1'b0;
      total++; if (lat != 7 || mat !== ref_op(OP_SUBTRACT, a, b)) begin bad++; $display("FAIL stale_done lat=%0d mat=%h want lat=7 mat=%h", lat, mat, ref_op(OP_SUBTRACT, a, b)); end
   endtask

   task automatic test_random();
      logic [255:0] a, b, mat, lb; logic err; int lat, want_lat; bit ind1, en, st, rdy, nen, oe;
      logic [2:0] op;
      for (int i = 0; i < 20; i++) begin
         op = 3'($urandom_range(0, 4));
         a = rand256(); b = rand256();
         want_lat = (op == OP_TRANSPOSE) ? 6 : 7;
         do_cmd(op, a, b, $urandom_range(0, 3), mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
         total++;
         if (mat !== ref_op(op, a, b) || err !== 1'b0 || lat != want_lat || st !== 1'b1) begin
            bad++;
            $display("FAIL random_%0d op=%0d lat=%0d err=%b stable=%b mat=%h want lat=%0d err=0 stable=1 mat=%h",
                     i, op, lat, err, st, mat, want_lat, ref_op(op, a, b));
         end
      end
   endtask

   task automatic test_stall_and_reset();
      logic [255:0] a, b, mat, lb; logic err; int lat, n; bit ind1, en, st, rdy, nen, oe, got_rsp;
      a = rand256(); b = rand256();
      do_cmd(OP_MULTIPLY, a, b, 10, mat, err, lat, ind1, en, lb, st, rdy, nen, oe);
      total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b want=1", st); end
      total++; if (mat !== ref_op(OP_MULTIPLY, a, b) || lat != 7) begin bad++; $display("FAIL stall_multiply lat=%0d mat=%h want lat=7 mat=%h", lat, mat, ref_op(OP_MULTIPLY, a, b)); end

      @(negedge clk);
      ifc.cmdValid = 1'b1; ifc.cmdOpCode = OP_MULTIPLY; ifc.cmdOperandA = rand256(); ifc.cmdOperandB = rand256();
      n = 0;
      while (!ifc.cmdReady && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      ifc.cmdValid = 1'b0;
      n = 0;
      while (!ifc.readnWrite && n < 20) begin @(negedge clk); n++; end
      total++; if (ifc.readnWrite !== 1'b1) begin bad++; $display("FAIL reset_mid_exec_reach got=%b want=1", ifc.readnWrite); end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      total++; if (ifc.nALUenable !== 1'b1 || ifc.dataBusOE !== 1'b0 || ifc.rspValid !== 1'b0) begin
         bad++; $display("FAIL reset_mid_exec_release nen=%b oe=%b rspValid=%b want 1 0 0", ifc.nALUenable, ifc.dataBusOE, ifc.rspValid);
      end
      reset = 1'b0;
      got_rsp = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ifc.rspValid) got_rsp = 1'b1;
      end
      total++; if (got_rsp !== 1'b0) begin bad++; $display("FAIL reset_mid_exec_no_rsp got=%b want=0", got_rsp); end
      total++; if (ifc.cmdReady !== 1'b1) begin bad++; $display("FAIL reset_mid_exec_ready got=%b want=1", ifc.cmdReady); end
   endtask

   task automatic test_bus_rules();
      total++; if (rule_viol != 0) begin bad++; $display("FAIL bus_oe_rule got=%0d want=0", rule_viol); end
      total++; if (contention != 0) begin bad++; $display("FAIL bus_contention got=%0d want=0", contention); end
   endtask

   initial begin
      ifc.cmdValid    = 1'b0;
      ifc.cmdOpCode   = 3'd0;
      ifc.cmdOperandA = '0;
      ifc.cmdOperandB = '0;
      ifc.rspReady    = 1'b0;
      test_reset();
      test_add();
      test_transpose();
      test_scale();
      test_illegal();
      test_timeout();
      test_stale_done();
      test_random();
      test_stall_and_reset();
      test_bus_rules();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
